// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions.
//   RX FSM state encoding (3-bit, same encoding style as the TX side),
//   parity type constants and the supported oversampling ratios.
package uart_pkg;

   localparam logic [2:0] RX_IDLE   = 3'd0;
   localparam logic [2:0] RX_START  = 3'd1;
   localparam logic [2:0] RX_DATA   = 3'd2;
   localparam logic [2:0] RX_PARITY = 3'd3;
   localparam logic [2:0] RX_STOP   = 3'd4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler -- three-point oversampler with majority vote.
//   CLK, RST     : clock, synchronous active-low reset
//   RX_IN        : serial line (idle high)
//   edge_cnt     : position inside the current bit period (0..prescale-1)
//   prescale     : latched oversampling ratio (8/16/32)
//   sampled_bit  : majority of the three mid-bit samples; valid from
//                  edge_cnt = prescale/2+2 until the end of the bit
module uart_rx_sampler (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic [5:0] edge_cnt,
   input  logic [5:0] prescale,
   output logic       sampled_bit
);

   logic [5:0] half;
   logic [2:0] smp;

   assign half = prescale >> 1;

   // Samples straddle the bit centre: P/2-1, P/2, P/2+1.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         smp <= 3'b111;
      end else begin
         if (edge_cnt == half - 6'd1) smp[0] <= RX_IN;
         if (edge_cnt == half)        smp[1] <= RX_IN;
         if (edge_cnt == half + 6'd1) smp[2] <= RX_IN;
      end
   end

   assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame -- UART receiver: start-bit detection with glitch rejection,
// majority-voted LSB-first deserialisation, optional parity and stop checks.
//   CLK, RST      : clock, synchronous active-low reset
//   RX_IN         : serial line, idle high, already synchronised
//   Prescale      : oversampling ratio (16/32, anything else means 8)
//   PAR_EN        : frame carries a parity bit
//   PAR_TYP       : 0 even, 1 odd
//   P_DATA        : last correctly received word (held between frames)
//   data_valid    : 1-cycle strobe, P_DATA just updated
//   parity_error  : 1-cycle strobe, parity mismatch (stop bit was good)
//   stop_error    : 1-cycle strobe, stop bit sampled 0
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   output logic [DATA_WIDTH-1:0]     P_DATA,
   output logic                      data_valid,
   output logic                      parity_error,
   output logic                      stop_error
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [2:0]            state;
   logic [5:0]            edge_cnt;
   logic [5:0]            presc;
   logic [5:0]            presc_in;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  par_bad;
   logic                  sampled_bit;
   logic                  bit_end;
   logic                  vote_ready;
   logic                  par_exp;

   always_comb begin
      presc_in = 6'(PRESCALE_8);
      if (Prescale == PRESCALE_WIDTH'(PRESCALE_16)) presc_in = 6'(PRESCALE_16);
      if (Prescale == PRESCALE_WIDTH'(PRESCALE_32)) presc_in = 6'(PRESCALE_32);
   end

   assign bit_end    = (edge_cnt == presc - 6'd1);
   // First cycle in which all three samples of the current bit are in.
   assign vote_ready = (edge_cnt == (presc >> 1) + 6'd2);
   assign par_exp    = (^shreg) ^ (par_typ_q == PAR_ODD);

   uart_rx_sampler u_sampler (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (RX_IN),
      .edge_cnt    (edge_cnt),
      .prescale    (presc),
      .sampled_bit (sampled_bit)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state        <= RX_IDLE;
         edge_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         presc        <= 6'(PRESCALE_8);
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_bad      <= 1'b0;
         P_DATA       <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
         edge_cnt     <= bit_end ? 6'd0 : edge_cnt + 6'd1;

         case (state)
            RX_IDLE: begin
               edge_cnt <= '0;
               bit_cnt  <= '0;
               par_bad  <= 1'b0;
               if (!RX_IN) begin
                  state     <= RX_START;
                  presc     <= presc_in;
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
               end
            end
            RX_START: begin
               // A start bit that votes high was a glitch: drop back silently.
               if (vote_ready && sampled_bit) begin
                  state    <= RX_IDLE;
                  edge_cnt <= '0;
               end else if (bit_end) begin
                  state   <= RX_DATA;
                  bit_cnt <= '0;
               end
            end
            RX_DATA: begin
               if (bit_end) begin
                  shreg[bit_cnt] <= sampled_bit;
                  if (bit_cnt == BIT_W'(DATA_WIDTH - 1))
                     state <= par_en_q ? RX_PARITY : RX_STOP;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end
            end
            RX_PARITY: begin
               if (bit_end) begin
                  par_bad <= (sampled_bit != par_exp);
                  state   <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (bit_end) begin
                  if (!sampled_bit) begin
                     stop_error <= 1'b1;
                  end else if (par_bad) begin
                     parity_error <= 1'b1;
                  end else begin
                     data_valid <= 1'b1;
                     P_DATA     <= shreg;
                  end
                  par_bad <= 1'b0;
                  // The sample just taken is the first of the next bit: a low
                  // line is already the next start bit.
                  state   <= RX_IN ? RX_IDLE : RX_START;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

   localparam logic [1:0] K_VALID = 2'd0;
   localparam logic [1:0] K_PAR   = 2'd1;
   localparam logic [1:0] K_STOP  = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       parity_error;
   logic       stop_error;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];
   int   valid_cyc[$];
   logic [7:0] model_pdata = 8'h00;

   uart_rx_frame dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_IN        (RX_IN),
      .Prescale     (Prescale),
      .PAR_EN       (PAR_EN),
      .PAR_TYP      (PAR_TYP),
      .P_DATA       (P_DATA),
      .data_valid   (data_valid),
      .parity_error (parity_error),
      .stop_error   (stop_error)
   );

   always #5 CLK = ~CLK;

   // Scoreboard: every strobe pops one expected frame outcome.
   task automatic observe();
      int n;
      exp_t e;
      logic [1:0] k;
      n = int'(data_valid) + int'(parity_error) + int'(stop_error);
      if (n > 0) begin
         checks++;
         if (n > 1) begin
            errors++;
            $display("FAIL strobe_excl dv=%0b pe=%0b se=%0b", data_valid, parity_error, stop_error);
         end
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe dv=%0b pe=%0b se=%0b at cyc %0d",
                     data_valid, parity_error, stop_error, cyc);
         end else begin
            e = sb.pop_front();
            k = data_valid ? K_VALID : (parity_error ? K_PAR : K_STOP);
            if (k !== e.kind) begin
               errors++;
               $display("FAIL strobe_kind got %0d want %0d (data %h)", k, e.kind, e.data);
            end
            if (e.kind == K_VALID) model_pdata = e.data;
            checks++;
            if (P_DATA !== model_pdata) begin
               errors++;
               $display("FAIL p_data got %h want %h", P_DATA, model_pdata);
            end
         end
         if (data_valid) valid_cyc.push_back(cyc);
      end
   endtask

   task automatic cycle(input logic rx);
      RX_IN = rx;
      @(negedge CLK);
      cyc++;
      observe();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                             input logic ptyp, input logic bad_par, input logic stop_bit);
      exp_t e;
      logic pbit;
      Prescale = 6'(p);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      pbit     = (^d) ^ ptyp ^ bad_par;
      e.data   = d;
      e.kind   = !stop_bit ? K_STOP : ((pen && bad_par) ? K_PAR : K_VALID);
      sb.push_back(e);
      repeat (p) cycle(1'b0);
      for (int i = 0; i < 8; i++) repeat (p) cycle(d[i]);
      if (pen) repeat (p) cycle(pbit);
      repeat (p) cycle(stop_bit);
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s pending=%0d want 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      cycle(1'b1);
      cycle(1'b1);
      checks++;
      if ({P_DATA, data_valid, parity_error, stop_error} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h/%b%b%b want 00/000",
                  P_DATA, data_valid, parity_error, stop_error);
      end
      RST = 1'b1;
      idle(4);
   endtask

   task automatic test_basic_p8();
      int c0;
      valid_cyc.delete();
      c0 = cyc;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(10);
      check_drained("basic_p8");
      checks++;
      if (valid_cyc.size() != 1 || valid_cyc[0] - c0 != 10 * 8 + 1) begin
         errors++;
         $display("FAIL latency_p8 got n=%0d dt=%0d want n=1 dt=%0d",
                  valid_cyc.size(), (valid_cyc.size() > 0) ? valid_cyc[0] - c0 : -1, 81);
      end
   endtask

   task automatic test_parity_p16();
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(20);
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(20);
      check_drained("parity_p16");
      checks++;
      if (P_DATA !== 8'h3C) begin
         errors++;
         $display("FAIL parity_hold got %h want 3c", P_DATA);
      end
   endtask

   task automatic test_stop_p32();
      send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(40);
      send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(40);
      check_drained("stop_p32");
      checks++;
      if (P_DATA !== 8'h3C) begin
         errors++;
         $display("FAIL stop_hold got %h want 3c", P_DATA);
      end
   endtask

   task automatic test_glitch();
      Prescale = 6'd16;
      PAR_EN   = 1'b0;
      repeat (3) cycle(1'b0);
      idle(48);
      check_drained("glitch_silent");
      send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(20);
      check_drained("glitch_then_frame");
      checks++;
      if (P_DATA !== 8'h55) begin
         errors++;
         $display("FAIL glitch_frame got %h want 55", P_DATA);
      end
   endtask

   task automatic test_back_to_back();
      valid_cyc.delete();
      send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h80, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(12);
      check_drained("back_to_back");
      checks++;
      if (valid_cyc.size() != 2 || valid_cyc[1] - valid_cyc[0] != 80) begin
         errors++;
         $display("FAIL b2b_gap got n=%0d gap=%0d want n=2 gap=80", valid_cyc.size(),
                  (valid_cyc.size() == 2) ? valid_cyc[1] - valid_cyc[0] : -1);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d        = 8'h99;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      repeat (8) cycle(1'b0);
      for (int i = 0; i < 3; i++) repeat (8) cycle(d[i]);
      RST = 1'b0;
      cycle(1'b1);
      model_pdata = 8'h00;
      checks++;
      if ({P_DATA, data_valid, parity_error, stop_error} !== 11'd0) begin
         errors++;
         $display("FAIL reset_mid got %h/%b%b%b want 00/000",
                  P_DATA, data_valid, parity_error, stop_error);
      end
      RST = 1'b1;
      idle(40);
      check_drained("reset_mid_silent");
      send_frame(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(12);
      check_drained("reset_then_frame");
      checks++;
      if (P_DATA !== 8'h99) begin
         errors++;
         $display("FAIL reset_frame got %h want 99", P_DATA);
      end
   endtask

   initial begin
      RST      = 1'b0;
      RX_IN    = 1'b1;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      test_reset();
      test_basic_p8();
      test_parity_p16();
      test_stop_p32();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
